// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - boot word stream and instruction memory write port bundle
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // master: host source that also observes the memory write port
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // slave: the loader itself
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - clears instruction memory to NOP, loads a boot image, then releases cpu reset
module imem_loader #(
  parameter int          DEPTH      = 1024,
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] NOP_WORD   = 32'h00000013,
  parameter int          RESET_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   COUNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_cnt, addr_next;
  logic [ADDR_W:0]   count_next;
  logic              ovf_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;

  always_comb begin
    state_next     = state;
    addr_next      = addr_cnt;
    count_next     = word_count;
    ovf_next       = overflow;
    hold_next      = hold_cnt;
    bus.in_ready   = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_addr  = addr_cnt;
    bus.imem_wdata = NOP_WORD;

    case (state)
      S_IDLE, S_RUN: begin
        if (start) begin
          state_next = S_CLEAR;
          addr_next  = '0;
          count_next = '0;
          ovf_next   = 1'b0;
        end
      end

      // Address wraps to 0 after DEPTH-1 because DEPTH is a power of two
      S_CLEAR: begin
        bus.imem_we = 1'b1;
        addr_next   = addr_cnt + 1'b1;
        if (addr_cnt == ADDR_LAST) begin
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        bus.in_ready   = 1'b1;
        bus.imem_we    = bus.in_valid;
        bus.imem_wdata = bus.in_data;
        if (bus.in_valid) begin
          addr_next  = addr_cnt + 1'b1;
          count_next = word_count + 1'b1;
          if (word_count == COUNT_LAST) begin
            // memory is full: stop even if the image claims to continue
            state_next = S_HOLD;
            hold_next  = '0;
            ovf_next   = overflow | ~bus.in_last;
          end else if (bus.in_last) begin
            state_next = S_HOLD;
            hold_next  = '0;
          end
        end
      end

      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = S_RUN;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_cnt   <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      hold_cnt   <= '0;
      cpu_reset  <= 1'b1;
    end else begin
      state      <= state_next;
      addr_cnt   <= addr_next;
      word_count <= count_next;
      overflow   <= ovf_next;
      hold_cnt   <= hold_next;
      cpu_reset  <= (state_next != S_RUN);
    end
  end

  assign busy = (state == S_CLEAR) || (state == S_LOAD) || (state == S_HOLD);
  assign done = (state == S_RUN);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader at DEPTH=16, RESET_HOLD=2
module tb_imem_loader;

  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam int          RH    = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cpu_reset, busy, done, overflow;
  logic [AW:0]   word_count;

  imem_loader_if #(.ADDR_W(AW)) ifc ();

  imem_loader #(
    .DEPTH(DEPTH), .ADDR_W(AW), .NOP_WORD(NOP), .RESET_HOLD(RH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(ifc),
    .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .word_count(word_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem     [DEPTH];
  logic [31:0] exp_img [DEPTH];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          waddr = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifc.imem_we === 1'b1) mem[ifc.imem_addr] <= ifc.imem_wdata;
  end

  // every observed write must match the head of the expected queue
  always @(negedge clk) begin
    if (ifc.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 64'(ifc.imem_we), 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 64'(ifc.imem_addr), 64'(e.a));
        check_eq("wr_data", 64'(ifc.imem_wdata), 64'(e.d));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session();
    start = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back('{a: AW'(i), d: NOP});
      exp_img[i] = NOP;
    end
    waddr = 0;
    step();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ifc.in_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    check_eq("ready_reached", 64'(ifc.in_ready), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_last  = last;
    exp_q.push_back('{a: AW'(waddr), d: d});
    exp_img[waddr] = d;
    waddr++;
    step();
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic gap();
    ifc.in_valid = 1'b0;
    step();
  endtask

  task automatic wait_run(input int exp_lat);
    int n = 0;
    while (cpu_reset !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check_eq("run_reached", 64'(done), 64'd1);
    if (exp_lat > 0) check_eq("latency", 64'(cyc - start_cyc), 64'(exp_lat));
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) check_eq(tag, {28'(i), mem[i]}, {28'(i), exp_img[i]});
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    ifc.in_last  = 1'b0;

    step();
    step();
    reset = 1'b0;
    check_eq("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_word_count", 64'(word_count), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_in_ready", 64'(ifc.in_ready), 64'd0);
    check_eq("rst_imem_we", 64'(ifc.imem_we), 64'd0);

    // image load, no gaps
    begin_session();
    check_eq("clear_busy", 64'(busy), 64'd1);
    wait_ready();
    send_word(32'h00a00093, 1'b0);
    send_word(32'h00500113, 1'b0);
    send_word(32'h002081b3, 1'b1);
    wait_run(DEPTH + 3 + RH);
    check_eq("a_word_count", 64'(word_count), 64'd3);
    check_eq("a_overflow", 64'(overflow), 64'd0);
    check_eq("a_busy", 64'(busy), 64'd0);
    check_mem("a_mem");

    // reload from RUN with gaps in in_valid
    begin_session();
    check_eq("reload_cpu_reset", 64'(cpu_reset), 64'd1);
    check_eq("reload_done", 64'(done), 64'd0);
    wait_ready();
    send_word(32'h00a00093, 1'b0);
    gap();
    gap();
    send_word(32'h00500113, 1'b0);
    send_word(32'h002081b3, 1'b1);
    wait_run(DEPTH + 5 + RH);
    check_eq("b_word_count", 64'(word_count), 64'd3);
    check_mem("b_mem");

    // overflow: DEPTH words, none marked last
    begin_session();
    wait_ready();
    for (int i = 0; i < DEPTH; i++) send_word(32'h10000000 + 32'(i), 1'b0);
    check_eq("ovf_in_ready", 64'(ifc.in_ready), 64'd0);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 32'hdeadbeef;
    for (int i = 0; i < 4; i++) step();
    ifc.in_valid = 1'b0;
    wait_run(0);
    check_eq("ovf_flag", 64'(overflow), 64'd1);
    check_eq("ovf_word_count", 64'(word_count), 64'd16);
    check_mem("ovf_mem");

    // reset during LOAD
    begin_session();
    check_eq("clear_overflow", 64'(overflow), 64'd0);
    wait_ready();
    send_word(32'h00300193, 1'b0);
    reset = 1'b1;
    step();
    check_eq("mid_cpu_reset", 64'(cpu_reset), 64'd1);
    check_eq("mid_busy", 64'(busy), 64'd0);
    check_eq("mid_done", 64'(done), 64'd0);
    check_eq("mid_word_count", 64'(word_count), 64'd0);
    check_eq("mid_in_ready", 64'(ifc.in_ready), 64'd0);
    reset = 1'b0;
    step();

    // fresh load with a start pulse during CLEAR
    begin_session();
    for (int i = 0; i < 3; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("clear_start_busy", 64'(busy), 64'd1);
    wait_ready();
    send_word(32'h00100093, 1'b0);
    send_word(32'h00200113, 1'b1);
    wait_run(DEPTH + 2 + RH);
    check_eq("c_word_count", 64'(word_count), 64'd2);
    check_mem("c_mem");

    step();
    check_eq("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
